// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Valid/ready pipeline stage carrying a {pc, inst} pair, backed by a
//   2-entry skid buffer so upstream may stall one cycle late. Flush empties
//   the stage and presents a NOP bubble. Saturating counters track stall and
//   flush activity.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-low reset
//   in_valid   upstream entry valid
//   in_ready   stage can accept (registered state only)
//   in_pc      incoming pc
//   in_inst    incoming instruction
//   flush      kill all held entries
//   out_valid  head entry valid
//   out_ready  downstream accepts
//   out_pc     head pc
//   out_inst   head instruction, NOP_INST when out_valid=0
//   occupancy  held entries, 0..2
//   stall_cnt  cycles with out_valid & ~out_ready, saturating
//   flush_cnt  cycles with flush, saturating
//
// state | meaning
// ------+-------------------------------------
// EMPTY | no valid slots, outputs show bubble
// ONE   | main slot valid
// FULL  | main and skid slots valid, in_ready=0

module pipe_stage_skid #(
    parameter int                 PC_W     = 32,
    parameter int                 INST_W   = 32,
    parameter logic [INST_W-1:0]  NOP_INST = {INST_W{1'b0}},
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state;
    state_t             state_next;
    logic [PC_W-1:0]    main_pc;
    logic [INST_W-1:0]  main_inst;
    logic [PC_W-1:0]    skid_pc;
    logic [INST_W-1:0]  skid_inst;
    logic               main_valid;
    logic               in_fire;
    logic               out_fire;

    assign main_valid = (state != EMPTY);
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = main_valid & out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) state_next = ONE;
                ONE: begin
                    if (in_fire && !out_fire)      state_next = FULL;
                    else if (!in_fire && out_fire) state_next = EMPTY;
                end
                FULL:  if (out_fire) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    // Output logic
    always_comb begin
        out_valid = main_valid;
        in_ready  = rst & (state != FULL);
        case (state)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Main slot holds NOP_INST whenever it is not valid, so the outputs come
    // straight from the registers with no path from in_*.
    assign out_pc   = main_pc;
    assign out_inst = main_inst;

    // Data path
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_pc   <= '0;
            main_inst <= NOP_INST;
            skid_pc   <= '0;
            skid_inst <= '0;
        end else if (flush) begin
            // pc is captured even without in_valid to keep the old flush behaviour
            main_pc   <= in_pc;
            main_inst <= NOP_INST;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_pc   <= in_pc;
                        main_inst <= in_inst;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_pc   <= in_pc;
                        main_inst <= in_inst;
                    end else if (in_fire) begin
                        skid_pc   <= in_pc;
                        skid_inst <= in_inst;
                    end else if (out_fire) begin
                        main_inst <= NOP_INST;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_pc   <= skid_pc;
                        main_inst <= skid_inst;
                    end
                end
                default: ;
            endcase
        end
    end

    // Performance counters; stalls during a flush cycle still count
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_valid && !out_ready && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          CMAX = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [1:0]  occupancy;
    logic [3:0]  stall_cnt;
    logic [3:0]  flush_cnt;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .PC_W(32), .INST_W(32), .NOP_INST(NOP), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    // Reference model / scoreboard: entries queued on accept, popped on consume
    ent_t        mq[$];
    logic [31:0] m_last_pc;
    int          m_stall;
    int          m_flush;
    bit          armed = 0;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = (mq.size() > 0);
        chk("in_ready",  64'(in_ready),  64'(rst && mq.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(v));
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("out_pc",    64'(out_pc),    64'(v ? mq[0].pc : m_last_pc));
        chk("out_inst",  64'(out_inst),  64'(v ? mq[0].inst : NOP));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    endtask

    task automatic model_update(input logic r, iv, input logic [31:0] p, input logic f, ordy);
        bit ov, ird;
        ent_t e;
        if (!r) begin
            mq.delete();
            m_last_pc = '0;
            m_stall   = 0;
            m_flush   = 0;
            armed     = 1;
        end else begin
            ov  = (mq.size() > 0);
            ird = (mq.size() < 2);
            if (ov && !ordy && m_stall < CMAX) m_stall++;
            if (f) begin
                if (m_flush < CMAX) m_flush++;
                mq.delete();
                m_last_pc = p;
            end else begin
                if (ov && ordy) begin
                    e = mq.pop_front();
                    m_last_pc = e.pc;
                end
                if (iv && ird) begin
                    e.pc   = p;
                    e.inst = inst_of(p);
                    mq.push_back(e);
                end
            end
        end
    endtask

    task automatic step(input logic r, iv, input logic [31:0] p, input logic f, ordy);
        @(negedge clk);
        if (armed) check_outputs();
        rst       = r;
        in_valid  = iv;
        in_pc     = p;
        in_inst   = inst_of(p);
        flush     = f;
        out_ready = ordy;
        @(posedge clk);
        model_update(r, iv, p, f, ordy);
    endtask

    typedef struct {
        logic        r, iv;
        logic [31:0] pc;
        logic        f, ordy;
        int          occ;
        logic        ov;
        logic [31:0] opc;
        logic        ird;
        int          stall, flsh;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, iv, input logic [31:0] pc, input logic f, ordy,
                       input int occ, input logic ov, input logic [31:0] opc,
                       input logic ird, input int stall, flsh);
        vec_t v;
        v.r = r; v.iv = iv; v.pc = pc; v.f = f; v.ordy = ordy;
        v.occ = occ; v.ov = ov; v.opc = opc; v.ird = ird; v.stall = stall; v.flsh = flsh;
        tbl.push_back(v);
    endtask

    logic [31:0] seq_pc;

    initial begin
        //   r iv pc         f ordy | occ ov opc        ird stall flsh
        // reset
        add(0, 0, 32'h000, 0, 1,     0,  0, 32'h000,    0,  0,    0);
        add(0, 0, 32'h000, 0, 1,     0,  0, 32'h000,    0,  0,    0);
        // back-to-back stream
        add(1, 1, 32'h100, 0, 1,     1,  1, 32'h100,    1,  0,    0);
        add(1, 1, 32'h104, 0, 1,     1,  1, 32'h104,    1,  0,    0);
        add(1, 1, 32'h108, 0, 1,     1,  1, 32'h108,    1,  0,    0);
        add(1, 0, 32'h000, 0, 1,     0,  0, 32'h108,    1,  0,    0);
        // backpressure into skid
        add(1, 1, 32'h200, 0, 0,     1,  1, 32'h200,    1,  0,    0);
        add(1, 1, 32'h204, 0, 0,     2,  1, 32'h200,    0,  1,    0);
        add(1, 1, 32'h208, 0, 0,     2,  1, 32'h200,    0,  2,    0);
        add(1, 1, 32'h208, 0, 1,     1,  1, 32'h204,    1,  2,    0);
        add(1, 1, 32'h208, 0, 1,     1,  1, 32'h208,    1,  2,    0);
        add(1, 0, 32'h000, 0, 1,     0,  0, 32'h208,    1,  2,    0);
        // flush while full
        add(1, 1, 32'h310, 0, 0,     1,  1, 32'h310,    1,  2,    0);
        add(1, 1, 32'h314, 0, 0,     2,  1, 32'h310,    0,  3,    0);
        add(1, 1, 32'h300, 1, 0,     0,  0, 32'h300,    1,  4,    1);
        add(1, 0, 32'h000, 0, 1,     0,  0, 32'h300,    1,  4,    1);
        // reset mid-operation
        add(1, 1, 32'h400, 0, 0,     1,  1, 32'h400,    1,  4,    1);
        add(1, 1, 32'h404, 0, 0,     2,  1, 32'h400,    0,  5,    1);
        add(0, 1, 32'h408, 0, 0,     0,  0, 32'h000,    0,  0,    0);
        add(1, 0, 32'h000, 0, 1,     0,  0, 32'h000,    1,  0,    0);

        foreach (tbl[k]) begin
            step(tbl[k].r, tbl[k].iv, tbl[k].pc, tbl[k].f, tbl[k].ordy);
            #1;
            chk($sformatf("vec%0d occupancy", k), 64'(occupancy), 64'(tbl[k].occ));
            chk($sformatf("vec%0d out_valid", k), 64'(out_valid), 64'(tbl[k].ov));
            chk($sformatf("vec%0d out_pc", k),    64'(out_pc),    64'(tbl[k].opc));
            chk($sformatf("vec%0d in_ready", k),  64'(in_ready),  64'(tbl[k].ird));
            chk($sformatf("vec%0d stall_cnt", k), 64'(stall_cnt), 64'(tbl[k].stall));
            chk($sformatf("vec%0d flush_cnt", k), 64'(flush_cnt), 64'(tbl[k].flsh));
        end

        // Counter saturation: stall
        step(1, 1, 32'h500, 0, 0);
        for (int c = 0; c < 20; c++) step(1, 0, 32'h0, 0, 0);
        #1;
        chk("stall_sat", 64'(stall_cnt), 64'd15);
        // Counter saturation: flush
        for (int c = 0; c < 20; c++) step(1, 0, 32'h600 + 32'(c), 1, 1);
        #1;
        chk("flush_sat", 64'(flush_cnt), 64'd15);
        chk("flush_sat_stall_hold", 64'(stall_cnt), 64'd15);
        step(0, 0, 32'h0, 0, 1);

        // Random handshake against the model
        seq_pc = 32'h1000;
        for (int c = 0; c < 10000; c++) begin
            step(($urandom_range(0, 999) != 0),
                 ($urandom_range(0, 3) != 0),
                 seq_pc,
                 ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 2) != 0));
            seq_pc = seq_pc + 32'd4;
        end
        step(1, 0, 32'h0, 0, 1);
        @(negedge clk);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed 32-bit IF/ID-style stage register.
- Carries a {pc, inst} pair between two pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer lets upstream stall one cycle late without losing data.
- Flush kills in-flight entries and drives a NOP bubble; saturating counters record stall and flush activity for performance debug.

Parameters:
- PC_W, 32, width of the pc field
- INST_W, 32, width of the instruction field
- NOP_INST, {INST_W{1'b0}}, instruction value driven whenever the output is not valid
- CNT_W, 16, width of the stall/flush performance counters

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-low reset (state cleared on a rising clk edge while rst=0)
- in_valid  input  1  upstream has a valid {in_pc, in_inst}
- in_ready  output  1  stage can accept; in_fire = in_valid & in_ready
- in_pc  input  PC_W  incoming pc
- in_inst  input  INST_W  incoming instruction
- flush  input  1  kill all held entries this cycle
- out_valid  output  1  out_pc/out_inst are valid
- out_ready  input  1  downstream accepts; out_fire = out_valid & out_ready
- out_pc  output  PC_W  pc of the head entry
- out_inst  output  INST_W  instruction of the head entry, NOP_INST when out_valid=0
- occupancy  output  2  number of held entries, 0..2
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- flush_cnt  output  CNT_W  cycles with flush=1 (rst high), saturating

Behaviour:
- Storage: a main slot (drives the outputs) and a skid slot. Each slot holds pc, inst and a valid bit.
- States: EMPTY (no valid slots), ONE (main valid), FULL (main and skid valid). occupancy = 0/1/2 respectively.
- in_ready = rst & ~skid_valid.
  - Depends only on registered state, never on out_ready or in_valid.
  - Is 0 while rst=0.
- Reset (rst=0 at an edge), highest priority:
  - Both valids cleared; state EMPTY.
  - out_pc=0, out_inst=NOP_INST, skid contents=0.
  - stall_cnt=0, flush_cnt=0.
- Flush (rst=1, flush=1), next priority:
  - State goes to EMPTY.
  - main inst <= NOP_INST and main pc <= in_pc. The pc is captured even if in_valid=0, preserving the older stage's flush semantics.
  - The skid slot is invalidated.
  - An in_fire in the same cycle is discarded. An out_fire in the same cycle still counts as consumed by downstream.
- Normal transitions (rst=1, flush=0):
  - EMPTY: in_fire -> ONE, main <= in. Otherwise stay.
  - ONE:
    - in_fire & out_fire -> ONE, main <= in.
    - in_fire & ~out_fire -> FULL, skid <= in.
    - ~in_fire & out_fire -> EMPTY, main inst <= NOP_INST, main pc holds.
    - Neither -> hold.
  - FULL: in_ready=0.
    - out_fire -> ONE, main <= skid, skid invalidated.
    - Otherwise hold.
- Ordering is strict FIFO; no entry is duplicated or dropped except by flush or reset.
- Latency: in_fire at edge N gives out_valid=1 after edge N (visible in cycle N+1).
- Throughput is 1 entry/cycle when out_ready is held high.
- Outputs:
  - out_valid = main_valid.
  - out_pc/out_inst come from the main registers, with no combinational path from in_* to out_*.
  - out_inst equals NOP_INST whenever out_valid=0.
- Counters:
  - stall_cnt increments at each edge where out_valid=1, out_ready=0 and rst=1; this includes flush cycles.
  - flush_cnt increments at each edge where flush=1 and rst=1.
  - Both hold at 2^CNT_W-1 (no wrap).
- Outputs hold their values while state holds; in_* changes while in_ready=0 have no effect.

Test Plan:
- Reset, then stream: rst=0 for 2 cycles, then rst=1, out_ready=1, send pc 0x100/0x104/0x108 back-to-back -> out_valid one cycle after each in_fire; outputs in order; occupancy never exceeds 1; in_ready stays 1.
- Backpressure and skid: out_ready=0, send 0x200 then 0x204 -> occupancy 1 then 2; in_ready=0 after second accept; 0x208 held off. Raise out_ready -> 0x200, 0x204, 0x208 emerge in order; stall_cnt equals the number of stalled out_valid cycles.
- Flush while FULL: occupancy=2, assert flush with in_valid=1, in_pc=0x300 -> next cycle out_valid=0, out_inst=NOP_INST, out_pc=0x300, occupancy=0, flush_cnt=1; 0x300 never appears with valid.
- Reset mid-operation: occupancy=2, stall_cnt=5, drive rst=0 for one edge -> all outputs at reset values, counters 0, in_ready=0 during reset and 1 after release.
- Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15; same check for flush_cnt with 20 flush cycles.
- Random handshake: random in_valid/out_ready/flush for 10k cycles against a queue scoreboard -> no loss/duplication outside flushes; out_inst==NOP_INST whenever out_valid=0.
